pc_seq_ctrl: RTL and testbench
==============================

// Module: pc_seq_ctrl
// PURPOSE
//  Sequences the fetch PC for the 5-stage core: picks next PC (exception > branch > PC+4),
//  runs the req/ack handshake to instruction memory, merges stage stall requests into a
//  per-stage stall vector, issues a pipeline flush on exceptions. Sits between fetch and
//  the instruction bus; replaces the free-running PC counter.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded at reset
//  ACK_TIMEOUT  16             cycles without if_ack before fetch_err pulses (>=2)
// PORTS
//  clk            in   1   core clock, all state on posedge
//  reset_n        in   1   asynchronous, active-low reset
//  stall_req      in   3   [0]=ID, [1]=EX, [2]=MEM stage stall requests
//  branch_flag    in   1   branch taken, valid this cycle
//  branch_target  in   32  branch destination
//  excp_flag      in   1   exception taken, valid this cycle
//  excp_vector    in   32  exception handler address
//  if_ack         in   1   imem has accepted/returned current if_addr
//  if_req         out  1   fetch request
//  if_addr        out  32  fetch address (= pc)
//  pc             out  32  current fetch PC
//  ce             out  1   fetch enable (0 in reset and first cycle after)
//  stall          out  6   {wb,mem,ex,id,if,pc} stall vector
//  flush          out  1   one-cycle pipeline flush
//  fetch_err      out  1   one-cycle pulse on ack timeout
// BEHAVIOUR
//  Reset: pc=RESET_PC, ce=0, if_req=0, stall=0, flush=0, fetch_err=0, pend_valid=0, st=IDLE.
//  FSM IDLE -> FETCH unconditionally next cycle; ce=1 from that edge on.
//  FETCH: if_req=1, if_addr=pc, both stable until if_ack sampled high.
//   On if_ack with no stall: pc <= next_pc, stay FETCH (back-to-back, 1 fetch/cycle).
//   On if_ack with stall[0]=1: pc <= next_pc, go HOLD.
//  HOLD: if_req=0, pc held; redirects still latched; -> FETCH when stall[0] drops.
//  next_pc priority: excp_flag ? excp_vector : branch_flag ? branch_target :
//   pend_valid ? pend_addr : pc+4. Bits [1:0] of any loaded PC forced to 0; +4 wraps mod 2^32.
//  Redirect while fetch outstanding (FETCH, no ack) or in HOLD: latched into pend_addr,
//   pend_valid=1; later exception overwrites pending branch, branch never overwrites
//   pending exception. Consumed (pend_valid=0) at the PC update that uses it.
//  Redirect in same cycle as if_ack: applied directly, nothing latched.
//  Stall vector (OR of sources):
//   stall_req[0] -> 6'b000111; [1] -> 6'b001111; [2] -> 6'b011111;
//   FETCH && !if_ack -> 6'b000011. Combinational from inputs and state.
//  excp_flag: flush=1 next cycle (registered, one pulse); stall forced 0 that cycle;
//   HOLD exits to FETCH immediately with pc=excp_vector.
//  Timeout: counter clears on ack or leaving FETCH, counts in FETCH while !if_ack; at
//   ACK_TIMEOUT-1 fetch_err pulses one cycle, counter restarts, request stays asserted.
//  Async reset mid-fetch: if_req drops immediately, pending redirect discarded.
// STRUCTURE
//  Package pc_seq_pkg: state enum {IDLE,FETCH,HOLD}, stall masks STALL_ID/EX/MEM/IF,
//   INSN_BYTES=4. Sub-module pc_ack_timer (timeout counter + fetch_err pulse).
//  Top holds FSM, pc/pend registers, next_pc mux, stall merge.
// TESTING
//  Reset release, if_ack tied 1 -> ce=1 at cycle 1, if_addr 0,4,8,C on successive cycles.
//  branch_flag=1 target 0x103 with ack same cycle -> next if_addr 0x100, no pending.
//  Branch to 0x200 at cycle ack low, ack 3 cycles later -> that fetch completes, then 0x200.
//  stall_req[1]=1 for 2 cycles -> stall=6'b001111, if_req low in HOLD, pc frozen, resumes +4.
//  Exception 0x180 during HOLD with pending branch -> flush pulse, pc=0x180, branch dropped.
//  if_ack held low 16 cycles -> fetch_err pulse at cycle 15, if_req still high, pc unchanged.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state enum, stall masks and PC helpers for the fetch PC sequencer
package pc_seq_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} st_e;
  // Stall vector bit order is {wb,mem,ex,id,if,pc}
  localparam logic [5:0] STALL_ID  = 6'b000111;
  localparam logic [5:0] STALL_EX  = 6'b001111;
  localparam logic [5:0] STALL_MEM = 6'b011111;
  localparam logic [5:0] STALL_IF  = 6'b000011;
  localparam logic [31:0] INSN_BYTES = 32'd4;
  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/pc_ack_timer.sv
// pc_ack_timer: counts cycles a fetch waits for ack and pulses fetch_err on timeout
//   i_clk       core clock
//   i_reset_n   async active-low reset
//   i_active    fetch request outstanding (FETCH state)
//   i_ack       imem acknowledge
//   o_fetch_err one-cycle pulse in the ACK_TIMEOUT-th consecutive cycle without ack
module pc_ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_active,
  input  logic i_ack,
  output logic o_fetch_err
);
  localparam int W = $clog2(ACK_TIMEOUT);
  logic [W-1:0] r_cnt;
  logic w_last;
  assign w_last = i_active && !i_ack && (r_cnt == W'(ACK_TIMEOUT - 1));
  assign o_fetch_err = w_last;
  // Restart after the pulse so a stuck request keeps reporting every ACK_TIMEOUT cycles
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) r_cnt <= '0;
    else r_cnt <= (!i_active || i_ack || w_last) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: fetch PC sequencer with imem req/ack handshake, stall merge and exception flush
//   i_clk, i_reset_n    clock, async active-low reset
//   i_stall_req[2:0]    {MEM,EX,ID} stage stall requests
//   i_branch_flag/target  taken branch redirect
//   i_excp_flag/vector    exception redirect (highest priority)
//   i_if_ack            imem accepted current o_if_addr
//   o_if_req, o_if_addr fetch request and address (= o_pc)
//   o_pc, o_ce          current fetch PC, fetch enable
//   o_stall[5:0]        {wb,mem,ex,id,if,pc} stall vector
//   o_flush             one-cycle flush after an exception
//   o_fetch_err         one-cycle ack-timeout pulse
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [2:0]  i_stall_req,
  input  logic        i_branch_flag,
  input  logic [31:0] i_branch_target,
  input  logic        i_excp_flag,
  input  logic [31:0] i_excp_vector,
  input  logic        i_if_ack,
  output logic        o_if_req,
  output logic [31:0] o_if_addr,
  output logic [31:0] o_pc,
  output logic        o_ce,
  output logic [5:0]  o_stall,
  output logic        o_flush,
  output logic        o_fetch_err
);
  st_e         r_st, w_st_nxt;
  logic [31:0] r_pc, w_pc_nxt, r_pend_addr, w_pend_addr_nxt, w_next_pc;
  logic        r_pend_valid, w_pend_valid_nxt, r_pend_excp, w_pend_excp_nxt;
  logic        r_ce, r_flush, w_fetch, w_latch;
  logic [5:0]  w_stall;
  assign w_fetch = (r_st == FETCH);
  // An exception releases every stall so the handler fetch can start at once
  assign w_stall = i_excp_flag ? 6'b0 :
    (i_stall_req[0] ? STALL_ID : 6'b0) | (i_stall_req[1] ? STALL_EX : 6'b0) |
    (i_stall_req[2] ? STALL_MEM : 6'b0) | ((w_fetch && !i_if_ack) ? STALL_IF : 6'b0);
  assign w_next_pc = align(i_excp_flag ? i_excp_vector : i_branch_flag ? i_branch_target :
    r_pend_valid ? r_pend_addr : r_pc + INSN_BYTES);
  // Redirects arriving while the PC cannot move are remembered until the next PC update
  assign w_latch = (w_fetch && !i_if_ack) || (r_st == HOLD);
  always_comb begin
    w_st_nxt = r_st;
    w_pc_nxt = r_pc;
    w_pend_addr_nxt = r_pend_addr;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_excp_nxt = r_pend_excp;
    if (w_latch && i_excp_flag) begin
      w_pend_addr_nxt = i_excp_vector;
      w_pend_valid_nxt = 1'b1;
      w_pend_excp_nxt = 1'b1;
    end else if (w_latch && i_branch_flag && !(r_pend_valid && r_pend_excp)) begin
      w_pend_addr_nxt = i_branch_target;
      w_pend_valid_nxt = 1'b1;
      w_pend_excp_nxt = 1'b0;
    end
    case (r_st)
      IDLE: w_st_nxt = FETCH;
      FETCH: if (i_if_ack) begin
        w_pc_nxt = w_next_pc;
        w_pend_valid_nxt = 1'b0;
        w_st_nxt = w_stall[0] ? HOLD : FETCH;
      end
      HOLD: if (i_excp_flag) begin
        w_pc_nxt = w_next_pc;
        w_pend_valid_nxt = 1'b0;
        w_st_nxt = FETCH;
      end else if (!w_stall[0]) w_st_nxt = FETCH;
      default: w_st_nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_st <= IDLE;
      r_pc <= align(RESET_PC);
      r_pend_addr <= '0;
      r_pend_valid <= 1'b0;
      r_pend_excp <= 1'b0;
      r_ce <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_st <= w_st_nxt;
      r_pc <= w_pc_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_excp <= w_pend_excp_nxt;
      r_ce <= 1'b1;
      r_flush <= i_excp_flag;
    end
  pc_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_active(w_fetch),
    .i_ack(i_if_ack),
    .o_fetch_err(o_fetch_err)
  );
  assign o_if_req = w_fetch;
  assign o_if_addr = r_pc;
  assign o_pc = r_pc;
  assign o_ce = r_ce;
  assign o_stall = w_stall;
  assign o_flush = r_flush;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed scenarios plus randomized run against a behavioural fetch model
module tb_pc_seq_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  stall_req = '0;
  logic        branch_flag = 1'b0, excp_flag = 1'b0, if_ack = 1'b0;
  logic [31:0] branch_target = '0, excp_vector = '0;
  logic        if_req, ce, flush, fetch_err;
  logic [31:0] if_addr, pc;
  logic [5:0]  stall;
  int errors = 0, checks = 0;

  pc_seq_ctrl dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_stall_req(stall_req),
    .i_branch_flag(branch_flag), .i_branch_target(branch_target),
    .i_excp_flag(excp_flag), .i_excp_vector(excp_vector), .i_if_ack(if_ack),
    .o_if_req(if_req), .o_if_addr(if_addr), .o_pc(pc), .o_ce(ce),
    .o_stall(stall), .o_flush(flush), .o_fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stall_req = '0; branch_flag = 0; excp_flag = 0; if_ack = 0;
    branch_target = '0; excp_vector = '0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    stall_req = '0; branch_flag = 0; excp_flag = 0; if_ack = 0;
    #3;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h want=0", pc); end
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL reset_ce got=%b want=0", ce); end
    checks++; if (if_req !== 1'b0) begin errors++; $display("FAIL reset_if_req got=%b want=0", if_req); end
    checks++; if (stall !== 6'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall); end
    checks++; if (flush !== 1'b0 || fetch_err !== 1'b0) begin errors++; $display("FAIL reset_pulses got flush=%b err=%b want 0 0", flush, fetch_err); end
  endtask

  task automatic test_sequential();
    do_reset();
    if_ack = 1'b1;
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL seq_ce_cycle0 got=%b want=0", ce); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ce !== 1'b1 || if_req !== 1'b1 || if_addr !== 32'(4 * i)) begin
        errors++; $display("FAIL seq_addr%0d got ce=%b req=%b addr=%h want 1 1 %h", i, ce, if_req, if_addr, 4 * i);
      end
    end
  endtask

  task automatic test_branch_same_cycle();
    branch_flag = 1'b1; branch_target = 32'h103;
    tick();
    branch_flag = 1'b0;
    checks++; if (if_addr !== 32'h100) begin errors++; $display("FAIL br_same got=%h want=100", if_addr); end
    tick();
    checks++; if (if_addr !== 32'h104) begin errors++; $display("FAIL br_same_nopend got=%h want=104", if_addr); end
  endtask

  task automatic test_branch_pending();
    if_ack = 1'b0; branch_flag = 1'b1; branch_target = 32'h200;
    tick();
    branch_flag = 1'b0;
    checks++; if (if_addr !== 32'h104 || if_req !== 1'b1 || stall !== 6'b000011) begin
      errors++; $display("FAIL br_pend_wait got addr=%h req=%b stall=%b want 104 1 000011", if_addr, if_req, stall);
    end
    repeat (2) tick();
    checks++; if (if_addr !== 32'h104) begin errors++; $display("FAIL br_pend_hold got=%h want=104", if_addr); end
    if_ack = 1'b1;
    tick();
    checks++; if (if_addr !== 32'h200) begin errors++; $display("FAIL br_pend_apply got=%h want=200", if_addr); end
    tick();
    checks++; if (if_addr !== 32'h204) begin errors++; $display("FAIL br_pend_next got=%h want=204", if_addr); end
  endtask

  task automatic test_stall();
    do_reset();
    if_ack = 1'b1;
    tick();
    stall_req = 3'b010;
    #2;
    checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL stall_vec1 got=%b want=001111", stall); end
    tick();
    checks++; if (if_req !== 1'b0 || pc !== 32'h4 || stall !== 6'b001111) begin
      errors++; $display("FAIL stall_hold got req=%b pc=%h stall=%b want 0 4 001111", if_req, pc, stall);
    end
    tick();
    stall_req = 3'b000;
    checks++; if (if_req !== 1'b0 || pc !== 32'h4) begin errors++; $display("FAIL stall_frozen got req=%b pc=%h want 0 4", if_req, pc); end
    tick();
    checks++; if (if_req !== 1'b1 || pc !== 32'h4) begin errors++; $display("FAIL stall_resume got req=%b pc=%h want 1 4", if_req, pc); end
    tick();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_plus4 got=%h want=8", pc); end
  endtask

  task automatic test_excp_hold();
    do_reset();
    if_ack = 1'b1;
    tick();
    stall_req = 3'b001;
    tick();
    branch_flag = 1'b1; branch_target = 32'h300;
    tick();
    branch_flag = 1'b0; excp_flag = 1'b1; excp_vector = 32'h181;
    #2;
    checks++; if (stall !== 6'b0) begin errors++; $display("FAIL excp_stall0 got=%b want=0", stall); end
    tick();
    excp_flag = 1'b0;
    checks++; if (pc !== 32'h180 || if_req !== 1'b1 || flush !== 1'b1) begin
      errors++; $display("FAIL excp_hold got pc=%h req=%b flush=%b want 180 1 1", pc, if_req, flush);
    end
    stall_req = 3'b000;
    tick();
    checks++; if (flush !== 1'b0 || pc !== 32'h184) begin
      errors++; $display("FAIL excp_drop_branch got flush=%b pc=%h want 0 184", flush, pc);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tick();
    for (int k = 0; k < 17; k++) begin
      #2;
      checks++; if (fetch_err !== (k == 15) || if_req !== 1'b1 || pc !== 32'h0) begin
        errors++; $display("FAIL timeout_k%0d got err=%b req=%b pc=%h want %b 1 0", k, fetch_err, if_req, pc, k == 15);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick();
    branch_flag = 1'b1; branch_target = 32'h440;
    tick();
    branch_flag = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checks++; if (if_req !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL async_rst got req=%b pc=%h want 0 0", if_req, pc); end
    tick();
    reset_n = 1'b1; if_ack = 1'b1;
    repeat (2) tick();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL async_pend_drop got=%h want=4", pc); end
  endtask

  // Model: started/fetching flags, pending redirect with priority (1 branch, 2 exception)
  bit          m_started, m_fetch, m_flush;
  int          m_pri, m_wait;
  logic [31:0] m_pc, m_pend, e_next;
  logic [5:0]  e_stall;
  bit          e_err;

  task automatic test_random();
    int n;
    do_reset();
    m_started = 0; m_fetch = 0; m_flush = 0; m_pri = 0; m_wait = 0; m_pc = 0; m_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      if_ack = ($urandom_range(9) < 7);
      branch_flag = ($urandom_range(7) == 0);
      excp_flag = ($urandom_range(15) == 0);
      stall_req = {$urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0};
      branch_target = $urandom;
      excp_vector = $urandom;
      @(negedge clk);
      n = stall_req[2] ? 5 : stall_req[1] ? 4 : stall_req[0] ? 3 : (m_fetch && !if_ack) ? 2 : 0;
      e_stall = excp_flag ? 6'd0 : 6'((1 << n) - 1);
      e_err = m_fetch && !if_ack && (m_wait % 16 == 15);
      checks++; if (if_req !== m_fetch || pc !== m_pc || if_addr !== m_pc || ce !== m_started ||
                    stall !== e_stall || flush !== m_flush || fetch_err !== e_err) begin
        errors++;
        $display("FAIL rand_c%0d got req=%b pc=%h addr=%h ce=%b stall=%b flush=%b err=%b want %b %h %h %b %b %b %b",
          c, if_req, pc, if_addr, ce, stall, flush, fetch_err, m_fetch, m_pc, m_pc, m_started, e_stall, m_flush, e_err);
      end
      e_next = excp_flag ? excp_vector : branch_flag ? branch_target : (m_pri > 0) ? m_pend : m_pc + 32'd4;
      e_next[1:0] = 2'b00;
      if (!m_started) begin
        m_started = 1; m_fetch = 1;
      end else if (m_fetch && if_ack) begin
        m_pc = e_next; m_pri = 0; m_wait = 0;
        if (e_stall[0]) m_fetch = 0;
      end else begin
        if (m_fetch) m_wait++; else m_wait = 0;
        if (excp_flag) begin m_pend = excp_vector; m_pri = 2; end
        else if (branch_flag && m_pri <= 1) begin m_pend = branch_target; m_pri = 1; end
        if (!m_fetch && excp_flag) begin m_pc = e_next; m_pri = 0; m_fetch = 1; end
        else if (!m_fetch && stall_req == 3'b000) m_fetch = 1;
      end
      m_flush = excp_flag;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_same_cycle();
    test_branch_pending();
    test_stall();
    test_excp_hold();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
